dcache_ctrl: RTL and testbench

DCACHE_CTRL -- requirements
Module: dcache_ctrl

---
 rtl/dcache_ctrl.sv | 102 ++++++++++
 tb/tb_dcache_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-back, write-allocate data cache controller with a blocking miss FSM
module dcache_ctrl #(
    parameter int LINE_NUM = 32,
    parameter int TAG_W    = 22
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          p1_MemRead_i,
    input  logic          p1_MemWrite_i,
    input  logic [31:0]   p1_addr_i,
    input  logic [31:0]   p1_data_i,
    output logic [31:0]   p1_data_o,
    output logic          p1_stall_o,
    input  logic [255:0]  mem_data_i,
    input  logic          mem_ack_i,
    output logic          mem_enable_o,
    output logic          mem_write_o,
    output logic [31:0]   mem_addr_o,
    output logic [255:0]  mem_data_o
);
    typedef enum logic [2:0] {IDLE, MISS, WRITEBACK, ALLOCATE, REFILL_DONE} state_t;
    state_t state, state_nx;
    logic [LINE_NUM-1:0] valid, dirty;
    logic [TAG_W-1:0] tag_mem [LINE_NUM];
    logic [255:0] data_mem [LINE_NUM];
    logic [4:0] idx;
    logic [2:0] wsel;
    logic [TAG_W-1:0] req_tag;
    logic access, hit, write_hit, refill, stall;
    logic unused_ok;
    assign unused_ok = ^p1_addr_i[1:0];
    assign idx = p1_addr_i[9:5];
    assign wsel = p1_addr_i[4:2];
    assign req_tag = p1_addr_i[31:10];
    assign access = p1_MemRead_i | p1_MemWrite_i;
    assign hit = access & valid[idx] & (tag_mem[idx] == req_tag);
    assign write_hit = (state == IDLE) & hit & p1_MemWrite_i;
    assign refill = (state == ALLOCATE) & mem_ack_i;
    assign p1_stall_o = rst_i & stall;
    assign p1_data_o = (state == IDLE && hit) ? data_mem[idx][{wsel, 5'b0} +: 32] : 32'd0;
    always_comb begin
        state_nx = state;
        stall = 1'b0;
        mem_enable_o = 1'b0;
        mem_write_o = 1'b0;
        mem_addr_o = 32'd0;
        mem_data_o = 256'd0;
        case (state)
            IDLE: begin
                stall = access & ~hit;
                state_nx = (access & ~hit) ? MISS : IDLE;
            end
            MISS: begin
                stall = 1'b1;
                state_nx = (valid[idx] & dirty[idx]) ? WRITEBACK : ALLOCATE;
            end
            WRITEBACK: begin
                stall = 1'b1;
                mem_enable_o = 1'b1;
                mem_write_o = 1'b1;
                mem_addr_o = {tag_mem[idx], idx, 5'b0};
                mem_data_o = data_mem[idx];
                state_nx = mem_ack_i ? ALLOCATE : WRITEBACK;
            end
            ALLOCATE: begin
                stall = 1'b1;
                mem_enable_o = 1'b1;
                mem_addr_o = {req_tag, idx, 5'b0};
                state_nx = mem_ack_i ? REFILL_DONE : ALLOCATE;
            end
            REFILL_DONE: begin
                stall = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
            valid <= '0;
            dirty <= '0;
        end else begin
            state <= state_nx;
            if (write_hit) dirty[idx] <= 1'b1;
            if (refill) begin
                valid[idx] <= 1'b1;
                dirty[idx] <= 1'b0;
            end
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            if (refill) begin
                tag_mem[idx] <= req_tag;
                data_mem[idx] <= mem_data_i;
            end else if (write_hit) begin
                data_mem[idx][{wsel, 5'b0} +: 32] <= p1_data_i;
            end
        end
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: randomized self-checking bench for dcache_ctrl against a line-level cache and memory model
module tb_dcache_ctrl;
    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    logic rd = 1'b0, wr = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [255:0] mem_data_i = '0;
    logic mem_ack_i = 1'b0;
    logic [31:0] p1_data_o, mem_addr_o;
    logic p1_stall_o, mem_enable_o, mem_write_o;
    logic [255:0] mem_data_o;
    int n_chk = 0, n_pass = 0;
    bit mv [32];
    bit md [32];
    logic [21:0] mt [32];
    logic [255:0] mdat [32];
    logic [255:0] mem [logic [31:0]];

    dcache_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .p1_MemRead_i(rd), .p1_MemWrite_i(wr), .p1_addr_i(addr), .p1_data_i(wdata),
        .p1_data_o(p1_data_o), .p1_stall_o(p1_stall_o),
        .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i), .mem_enable_o(mem_enable_o),
        .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic logic [255:0] line_of(input logic [31:0] a);
        logic [255:0] l;
        if (!mem.exists(a)) begin
            for (int k = 0; k < 8; k++) l[k*32 +: 32] = $urandom;
            mem[a] = l;
        end
        return mem[a];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 32; k++) begin
            mv[k] = 0;
            md[k] = 0;
        end
    endtask

    task automatic access(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d, input int fdly);
        int i, ws, stalls, dsum, cnt, dly;
        logic [21:0] t;
        logic [31:0] line_a, wb_addr, fetch_addr;
        logic [255:0] wb_data;
        bit exp_wb, got_wb, got_fetch;
        i = int'(a[9:5]);
        ws = int'(a[4:2]);
        t = a[31:10];
        line_a = {a[31:5], 5'b0};
        @(posedge clk_i);
        #1 rd = r; wr = w; addr = a; wdata = d;
        #1;
        if (!(mv[i] && mt[i] == t)) begin
            exp_wb = mv[i] && md[i];
            wb_addr = {mt[i], a[9:5], 5'b0};
            wb_data = mdat[i];
            if (exp_wb) mem[wb_addr] = wb_data;
            check("miss_stall", p1_stall_o, 1);
            stalls = 0; dsum = 0; cnt = 0; dly = 1;
            got_wb = 0; got_fetch = 0; fetch_addr = '0;
            while (p1_stall_o && stalls < 500) begin
                stalls++;
                if (mem_enable_o) begin
                    if (cnt == 0) begin
                        dly = fdly > 0 ? fdly : int'($urandom_range(1, 6));
                        dsum += dly;
                        if (mem_write_o) begin
                            got_wb = 1;
                            check("wb_addr", mem_addr_o, wb_addr);
                            check("wb_data", mem_data_o, wb_data);
                        end else begin
                            got_fetch = 1;
                            fetch_addr = mem_addr_o;
                        end
                    end
                    cnt++;
                    if (cnt == dly) begin
                        mem_ack_i = 1;
                        cnt = 0;
                        if (!mem_write_o) mem_data_i = line_of(line_a);
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    mem_ack_i = 1;
                end
                @(posedge clk_i);
                #1 mem_ack_i = 0;
                #1;
            end
            check("wb_seen", got_wb, exp_wb);
            check("fetch_seen", got_fetch, 1);
            check("fetch_addr", fetch_addr, line_a);
            check("stall_cycles", stalls, 3 + dsum);
            mv[i] = 1; md[i] = 0; mt[i] = t; mdat[i] = line_of(line_a);
        end
        check("hit_stall", p1_stall_o, 0);
        if (r && !w) check("rdata", p1_data_o, mdat[i][ws*32 +: 32]);
        if (w) begin
            mdat[i][ws*32 +: 32] = d;
            md[i] = 1;
        end
        if ($urandom_range(0, 3) == 0) mem_ack_i = 1;
        @(posedge clk_i);
        #1 mem_ack_i = 0; rd = 0; wr = 0;
        #1;
        check("idle_stall", p1_stall_o, 0);
        check("idle_data", p1_data_o, 0);
        check("idle_enable", mem_enable_o, 0);
    endtask

    initial begin
        int waited;
        model_reset();
        rd = 1; addr = 32'h40;
        repeat (2) @(posedge clk_i);
        #2;
        check("rst_stall", p1_stall_o, 0);
        check("rst_enable", mem_enable_o, 0);
        check("rst_data", p1_data_o, 0);
        check("rst_maddr", mem_addr_o, 0);
        rd = 0;
        @(posedge clk_i);
        #1 rst_i = 1;
        access(1, 0, 32'h0000_0040, 0, 10);
        access(0, 1, 32'h0000_0044, 32'hDEAD_BEEF, 0);
        access(1, 0, 32'h0000_0044, 0, 0);
        access(1, 0, 32'h0000_0440, 0, 0);
        access(1, 0, 32'h0000_0840, 0, 0);
        @(posedge clk_i);
        #1 rd = 1; addr = 32'h0000_00E0;
        waited = 0;
        while (!(mem_enable_o && !mem_write_o) && waited < 20) begin
            @(posedge clk_i);
            #1 waited++;
        end
        check("alloc_reached", waited < 20, 1);
        rst_i = 0;
        #1;
        check("midrst_stall", p1_stall_o, 0);
        check("midrst_enable", mem_enable_o, 0);
        check("midrst_write", mem_write_o, 0);
        check("midrst_maddr", mem_addr_o, 0);
        check("midrst_mdata", mem_data_o, 0);
        check("midrst_data", p1_data_o, 0);
        @(posedge clk_i);
        #1 rst_i = 1; rd = 0;
        model_reset();
        access(1, 0, 32'h0000_00E0, 0, 0);
        for (int n = 0; n < 300; n++) begin
            int op;
            logic [31:0] a;
            op = int'($urandom_range(0, 2));
            a = {20'd0, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), 2'b00};
            access(op != 1, op != 0, a, $urandom, 0);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
